// File: rtl/shared_bus_access_ctrl_pkg.sv
// Shared constants, state encoding and grant-decode helpers for the shared bus
// access controller.
package shared_bus_access_ctrl_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;
    localparam int DEF_AW  = 16;
    localparam int DEF_DW  = 32;
    localparam int DEF_LW  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    function automatic logic is_onehot(input logic [NUM_REQ-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    // Only meaningful for a one-hot input; the caller qualifies with is_onehot.
    function automatic logic [IDX_W-1:0] onehot_idx(input logic [NUM_REQ-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (v[i]) r = IDX_W'(i);
        return r;
    endfunction

endpackage

// File: rtl/bus_req_mux.sv
// Combinational 4:1 selection of one requester's burst fields by index.
module bus_req_mux
    import shared_bus_access_ctrl_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW,
    parameter int LW = DEF_LW
) (
    input  logic [IDX_W-1:0]      sel,
    input  logic [NUM_REQ*AW-1:0] req_addr_flat,
    input  logic [NUM_REQ-1:0]    req_wr_vector,
    input  logic [NUM_REQ*LW-1:0] req_len_flat,
    input  logic [NUM_REQ*DW-1:0] req_wdata_flat,
    output logic [AW-1:0]         addr,
    output logic                  wr,
    output logic [LW-1:0]         len,
    output logic [DW-1:0]         wdata
);

    always_comb begin
        addr  = req_addr_flat[int'(sel)*AW +: AW];
        wr    = req_wr_vector[sel];
        len   = req_len_flat[int'(sel)*LW +: LW];
        wdata = req_wdata_flat[int'(sel)*DW +: DW];
    end

endmodule

// File: rtl/shared_bus_access_ctrl.sv
// Runs the granted requester's burst on the shared memory bus and returns a
// one-cycle end-of-access pulse to close the arbiter loop.
module shared_bus_access_ctrl
    import shared_bus_access_ctrl_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW,
    parameter int LW = DEF_LW
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic [NUM_REQ-1:0]    gnt_vector,
    input  logic [NUM_REQ*AW-1:0] req_addr_flat,
    input  logic [NUM_REQ-1:0]    req_wr_vector,
    input  logic [NUM_REQ*LW-1:0] req_len_flat,
    input  logic [NUM_REQ*DW-1:0] req_wdata_flat,
    output logic [NUM_REQ-1:0]    end_access_vector,
    output logic [NUM_REQ-1:0]    wdata_ack_vector,
    output logic [NUM_REQ-1:0]    rvalid_vector,
    output logic [DW-1:0]         rdata,
    output logic                  bus_valid,
    output logic                  bus_wr,
    output logic [AW-1:0]         bus_addr,
    output logic [DW-1:0]         bus_wdata,
    input  logic                  bus_ready,
    input  logic [DW-1:0]         bus_rdata,
    output logic                  busy,
    output logic                  gnt_err
);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [LW-1:0]        len_q, len_d;
    logic [LW-1:0]        beat_cnt_q, beat_cnt_d;
    logic                 bus_valid_q, bus_valid_d;
    logic                 bus_wr_q, bus_wr_d;
    logic [AW-1:0]        bus_addr_q, bus_addr_d;
    logic [NUM_REQ-1:0]   end_access_q, end_access_d;
    logic [NUM_REQ-1:0]   rvalid_q, rvalid_d;
    logic [DW-1:0]        rdata_q, rdata_d;
    logic                 gnt_err_q, gnt_err_d;
    logic                 busy_q, busy_d;

    logic [IDX_W-1:0]     mux_sel;
    logic [AW-1:0]        mux_addr;
    logic                 mux_wr;
    logic [LW-1:0]        mux_len;
    logic [DW-1:0]        mux_wdata;
    logic                 beat_acc;
    logic [NUM_REQ-1:0]   idx_vec;

    // While idle the mux looks at the incoming grant so the start fields can be
    // latched; afterwards it follows the latched index for the write data.
    assign mux_sel = (state_q == IDLE) ? onehot_idx(gnt_vector) : idx_q;

    bus_req_mux #(.AW(AW), .DW(DW), .LW(LW)) u_mux (
        .sel            (mux_sel),
        .req_addr_flat  (req_addr_flat),
        .req_wr_vector  (req_wr_vector),
        .req_len_flat   (req_len_flat),
        .req_wdata_flat (req_wdata_flat),
        .addr           (mux_addr),
        .wr             (mux_wr),
        .len            (mux_len),
        .wdata          (mux_wdata)
    );

    assign beat_acc = bus_valid_q & bus_ready;
    assign idx_vec  = NUM_REQ'(1) << idx_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        len_d        = len_q;
        beat_cnt_d   = beat_cnt_q;
        bus_valid_d  = bus_valid_q;
        bus_wr_d     = bus_wr_q;
        bus_addr_d   = bus_addr_q;
        end_access_d = '0;
        rvalid_d     = '0;
        rdata_d      = rdata_q;
        gnt_err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_onehot(gnt_vector)) begin
                    idx_d       = mux_sel;
                    len_d       = mux_len;
                    bus_wr_d    = mux_wr;
                    bus_addr_d  = mux_addr;
                    beat_cnt_d  = '0;
                    bus_valid_d = 1'b1;
                    state_d     = ACCESS;
                end else if (gnt_vector != '0) begin
                    gnt_err_d = 1'b1;
                end
            end
            ACCESS: begin
                if (beat_acc) begin
                    if (!bus_wr_q) begin
                        rvalid_d = idx_vec;
                        rdata_d  = bus_rdata;
                    end
                    if (beat_cnt_q == len_q) begin
                        bus_valid_d  = 1'b0;
                        bus_wr_d     = 1'b0;
                        bus_addr_d   = '0;
                        end_access_d = idx_vec;
                        state_d      = DONE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + LW'(1);
                        bus_addr_d = bus_addr_q + AW'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            len_q        <= '0;
            beat_cnt_q   <= '0;
            bus_valid_q  <= 1'b0;
            bus_wr_q     <= 1'b0;
            bus_addr_q   <= '0;
            end_access_q <= '0;
            rvalid_q     <= '0;
            rdata_q      <= '0;
            gnt_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            beat_cnt_q   <= beat_cnt_d;
            bus_valid_q  <= bus_valid_d;
            bus_wr_q     <= bus_wr_d;
            bus_addr_q   <= bus_addr_d;
            end_access_q <= end_access_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            gnt_err_q    <= gnt_err_d;
            busy_q       <= busy_d;
        end
    end

    assign end_access_vector = end_access_q;
    assign rvalid_vector     = rvalid_q;
    assign rdata             = rdata_q;
    assign bus_valid         = bus_valid_q;
    assign bus_wr            = bus_wr_q;
    assign bus_addr          = bus_addr_q;
    assign busy              = busy_q;
    assign gnt_err           = gnt_err_q;
    // Write data only reaches the bus while a beat is actually offered.
    assign bus_wdata         = bus_valid_q ? mux_wdata : '0;
    assign wdata_ack_vector  = (beat_acc && bus_wr_q) ? idx_vec : '0;

endmodule
